// File: rtl/adder_seq_pkg.sv
// Shared types and helpers for the adder operand sequencer.
package adder_seq_pkg;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESULT = 2'd2
    } state_t;

    // Reference result at full width so the carry out is kept.
    function automatic logic [WIDTH:0] golden_sum(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             ci
    );
        return (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(ci);
    endfunction

endpackage

// File: rtl/adder_op_seq.sv
// Operand sequencer and checked result capture around a slow combinational adder.
module adder_op_seq #(
    parameter int unsigned WIDTH         = adder_seq_pkg::WIDTH,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_CNT_W     = adder_seq_pkg::ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_ci,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_ci,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_co,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_sum,
    output logic                 out_co,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 busy
);
    import adder_seq_pkg::*;

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     golden;
    logic               accept;
    logic               mismatch;

    assign in_ready = (state == IDLE) || ((state == RESULT) && out_ready);
    assign accept   = in_valid && in_ready;
    assign mismatch = ({add_co, add_sum} != golden);
    assign busy     = (state != IDLE);

    // Accept is evaluated after the state case so it wins on the back-to-back retire edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            golden    <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_ci    <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_co    <= 1'b0;
            out_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                end
                SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        out_sum   <= add_sum;
                        out_co    <= add_co;
                        out_err   <= mismatch;
                        out_valid <= 1'b1;
                        state     <= RESULT;
                        if (mismatch && (err_cnt != '1)) begin
                            err_cnt <= err_cnt + ERR_CNT_W'(1);
                        end
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (accept) begin
                add_a  <= in_a;
                add_b  <= in_b;
                add_ci <= in_ci;
                golden <= (WIDTH+1)'(golden_sum(in_a, in_b, in_ci));
                cnt    <= CNT_W'(SETTLE_CYCLES - 1);
                state  <= SETTLE;
            end
        end
    end

endmodule
